bus_xcvr_ctl: RTL

- Sequencer that drives the direction (DR) and enable (CS_n) pins of an 8-bit 74LS245-style data transceiver, plus the peripheral data strobe.
- Sits directly upstream of the transceiver. The A side is the controller/CPU side; the B side is the peripheral bus.
- Converts a single-cycle request (read or write) into a timed bus cycle: direction setup, strobe with wait states on ack, data hold, and a turnaround dead cycle.
- Captures read data and reports completion or timeout to the requester.

---
 rtl/bus_xcvr_ctl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/bus_xcvr_ctl.sv
// Bus-cycle sequencer for a 74LS245-style transceiver: direction setup, strobe
// with ack wait states, data hold and a turnaround cycle. All outputs registered.
module bus_xcvr_ctl #(
    parameter int SETUP_CYC = 1,
    parameter int MIN_WAIT  = 2,
    parameter int TIMEOUT   = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] rdata,
    output logic       xcvr_dr,
    output logic       xcvr_cs_n,
    output logic [7:0] a_out,
    output logic       a_oe,
    input  logic [7:0] a_in,
    output logic       strobe_n,
    input  logic       ack_n
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, TURN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rw_q, rw_d;
    logic            err_q, err_d;
    logic            ack_meta_q, ack_s_q;
    logic [7:0]      rdata_q, rdata_d;
    logic [7:0]      a_out_q, a_out_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_out_q, err_out_d;
    logic            dr_q, dr_d;
    logic            cs_n_q, cs_n_d;
    logic            a_oe_q, a_oe_d;
    logic            strobe_n_q, strobe_n_d;
    logic            drive_en;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        rw_d    = rw_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        a_out_d = a_out_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    rw_d    = rw;
                    a_out_d = wdata;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d = cnt_q + 1'b1;
                // ack_s must have returned high so a stale ack cannot end the next strobe
                if (int'(cnt_q) >= SETUP_CYC - 1 && ack_s_q) begin
                    state_d = STROBE;
                    cnt_d   = '0;
                end else if (int'(cnt_q) == TIMEOUT - 1) begin
                    state_d = TURN;
                    err_d   = 1'b1;
                end
            end
            STROBE: begin
                cnt_d = cnt_q + 1'b1;
                if (int'(cnt_q) >= MIN_WAIT - 1 && !ack_s_q) begin
                    state_d = HOLD;
                    err_d   = 1'b0;
                    if (rw_q) rdata_d = a_in;
                end else if (int'(cnt_q) == TIMEOUT - 1) begin
                    state_d = HOLD;
                    err_d   = 1'b1;
                end
            end
            HOLD: state_d = TURN;
            TURN: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so the registered pins line up with the state.
        drive_en   = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
        dr_d       = drive_en && !rw_d;
        a_oe_d     = drive_en && !rw_d;
        cs_n_d     = !((state_d == STROBE) || (state_d == HOLD));
        strobe_n_d = (state_d != STROBE);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == TURN);
        err_out_d  = (state_d == TURN) && err_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rw_q       <= 1'b0;
            err_q      <= 1'b0;
            ack_meta_q <= 1'b1;
            ack_s_q    <= 1'b1;
            rdata_q    <= '0;
            a_out_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_out_q  <= 1'b0;
            dr_q       <= 1'b0;
            cs_n_q     <= 1'b1;
            a_oe_q     <= 1'b0;
            strobe_n_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rw_q       <= rw_d;
            err_q      <= err_d;
            ack_meta_q <= ack_n;
            ack_s_q    <= ack_meta_q;
            rdata_q    <= rdata_d;
            a_out_q    <= a_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_out_q  <= err_out_d;
            dr_q       <= dr_d;
            cs_n_q     <= cs_n_d;
            a_oe_q     <= a_oe_d;
            strobe_n_q <= strobe_n_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_out_q;
    assign rdata     = rdata_q;
    assign xcvr_dr   = dr_q;
    assign xcvr_cs_n = cs_n_q;
    assign a_out     = a_out_q;
    assign a_oe      = a_oe_q;
    assign strobe_n  = strobe_n_q;

endmodule
